// File: rtl/fp_mul_arb_if.sv
// fp_mul_arb_if: requester, fp_mul and response signals of the shared multiplier arbiter
interface fp_mul_arb_if #(
   parameter int N   = 4,
   parameter int IDW = 2
);
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*32-1:0] req_a;
   logic [N*32-1:0] req_b;
   logic [N*3-1:0]  req_rm;
   logic [31:0]     mul_in1;
   logic [31:0]     mul_in2;
   logic [2:0]      mul_round_m;
   logic            mul_act;
   logic [31:0]     mul_out;
   logic            mul_ov;
   logic            mul_un;
   logic            mul_inv;
   logic            mul_inexact;
   logic            resp_valid;
   logic            resp_ready;
   logic [IDW-1:0]  resp_id;
   logic [31:0]     resp_data;
   logic [3:0]      resp_flags;
   logic            busy;
   modport master (
      input  req_valid, req_a, req_b, req_rm, mul_out, mul_ov, mul_un, mul_inv, mul_inexact, resp_ready,
      output req_ready, mul_in1, mul_in2, mul_round_m, mul_act, resp_valid, resp_id, resp_data, resp_flags, busy
   );
   modport slave (
      output req_valid, req_a, req_b, req_rm, mul_out, mul_ov, mul_un, mul_inv, mul_inexact, resp_ready,
      input  req_ready, mul_in1, mul_in2, mul_round_m, mul_act, resp_valid, resp_id, resp_data, resp_flags, busy
   );
endinterface

// File: rtl/fp_mul_arb.sv
// fp_mul_arb: round-robin sharing of one fixed-latency fp_mul among N requesters;
// results return in issue order through a credit-protected FIFO.
module fp_mul_arb #(
   parameter int N     = 4,
   parameter int IDW   = 2,
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   fp_mul_arb_if.master bus
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  grant_idx;
   logic [IDW-1:0]  next_ptr;
   logic [IDW:0]    sum;
   logic [2*N-1:0]  dbl;
   logic            found;
   logic            issue_ok;
   logic            accept;
   logic            push;
   logic            pop;
   logic [31:0]     a_sel;
   logic [31:0]     b_sel;
   logic [2:0]      rm_sel;
   // stage 0 is aligned with mul_in*, stage LAT with mul_out
   logic [LAT:0]    tag_valid;
   logic [IDW-1:0]  tag_id [LAT+1];
   logic [CW-1:0]   count;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [IDW+35:0] mem [DEPTH];
   int              outstanding;
   assign outstanding = $countones(tag_valid) + int'(count);
   assign issue_ok = rst && outstanding < DEPTH;
   assign dbl = {bus.req_valid, bus.req_valid} >> rr_ptr;
   always_comb begin
      found = 1'b0;
      sum = '0;
      for (int j = N - 1; j >= 0; j--)
         if (dbl[j]) begin
            found = 1'b1;
            sum = {1'b0, rr_ptr} + (IDW+1)'(j);
         end
      grant_idx = sum >= (IDW+1)'(N) ? IDW'(sum - (IDW+1)'(N)) : IDW'(sum);
      next_ptr = grant_idx == IDW'(N - 1) ? '0 : grant_idx + 1'b1;
      a_sel = '0;
      b_sel = '0;
      rm_sel = '0;
      for (int i = 0; i < N; i++)
         if (grant_idx == IDW'(i)) begin
            a_sel = bus.req_a[32*i +: 32];
            b_sel = bus.req_b[32*i +: 32];
            rm_sel = bus.req_rm[3*i +: 3];
         end
   end
   assign bus.req_ready = issue_ok && found ? N'(1) << grant_idx : '0;
   assign accept = |(bus.req_valid & bus.req_ready);
   assign push = tag_valid[LAT];
   assign pop = bus.resp_valid && bus.resp_ready;
   assign bus.resp_valid = count != '0;
   assign {bus.resp_id, bus.resp_flags, bus.resp_data} = bus.resp_valid ? mem[rd_ptr] : '0;
   assign bus.busy = |tag_valid || count != '0;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rr_ptr <= '0;
         tag_valid <= '0;
         count <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         bus.mul_in1 <= '0;
         bus.mul_in2 <= '0;
         bus.mul_round_m <= '0;
         bus.mul_act <= 1'b0;
      end else begin
         tag_valid <= {tag_valid[LAT-1:0], accept};
         bus.mul_act <= accept;
         if (accept) begin
            rr_ptr <= next_ptr;
            bus.mul_in1 <= a_sel;
            bus.mul_in2 <= b_sel;
            bus.mul_round_m <= rm_sel;
         end
         if (push)
            wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         assert (!(push && !pop && count == CW'(DEPTH)));
      end
   // payload path carries no reset; validity lives in tag_valid and count
   always_ff @(posedge clk) begin
      tag_id[0] <= grant_idx;
      for (int i = 1; i <= LAT; i++)
         tag_id[i] <= tag_id[i-1];
      if (push)
         mem[wr_ptr] <= {tag_id[LAT], bus.mul_inv, bus.mul_ov, bus.mul_un, bus.mul_inexact, bus.mul_out};
   end
endmodule

// File: tb/tb_fp_mul_arb.sv
// tb_fp_mul_arb: directed bench for fp_mul_arb with a two-stage behavioural fp_mul
module tb_fp_mul_arb;
   localparam logic [31:0] ONE = 32'h3F80_0000;
   localparam logic [31:0] TWO = 32'h4000_0000;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_checks = 0;
   int n_fail = 0;
   logic [35:0] p1;
   logic [35:0] p2;
   fp_mul_arb_if #(.N(4), .IDW(2)) bus ();
   fp_mul_arb #(.N(4), .IDW(2), .LAT(2), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // returns {inv,ov,un,inexact,product} for the handful of operand patterns used here
   function automatic logic [35:0] mul_model(input logic [31:0] x, input logic [31:0] y);
      if (x == 32'h7F80_0000 && y == 32'h0) return {4'b1000, 32'h7FC0_0000};
      if (x == 32'h7F7F_FFFF && y == TWO) return {4'b0101, 32'h7F80_0000};
      if (y == ONE) return {4'b0000, x};
      if (y == TWO) return {4'b0000, x[31], x[30:23] + 8'd1, x[22:0]};
      return {4'b0000, 32'hBAD0_0000};
   endfunction
   always @(posedge clk or negedge rst)
      if (!rst) begin
         p1 <= '0;
         p2 <= '0;
      end else begin
         p1 <= mul_model(bus.mul_in1, bus.mul_in2);
         p2 <= p1;
      end
   assign {bus.mul_inv, bus.mul_ov, bus.mul_un, bus.mul_inexact, bus.mul_out} = p2;

   task automatic do_reset;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_rm = '0;
      bus.resp_ready = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      bus.req_valid = 4'hF;
      bus.req_a = {4{ONE}};
      bus.req_b = {4{TWO}};
      bus.req_rm = '0;
      bus.resp_ready = 1'b1;
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (bus.req_ready !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_req_ready: got %h expected 0", bus.req_ready);
      end
      @(negedge clk);
      n_checks++;
      if ({bus.mul_act, bus.mul_in1, bus.mul_in2, bus.mul_round_m} !== 68'h0) begin
         n_fail++;
         $display("FAIL reset_mul: got act=%b in1=%h in2=%h rm=%h expected all 0", bus.mul_act, bus.mul_in1, bus.mul_in2, bus.mul_round_m);
      end
      n_checks++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_flags, bus.busy, bus.req_ready} !== 44'h0) begin
         n_fail++;
         $display("FAIL reset_resp: got valid=%b id=%h data=%h flags=%h busy=%b ready=%h expected all 0", bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_flags, bus.busy, bus.req_ready);
      end
   endtask

   task automatic test_single;
      do_reset;
      bus.req_valid = 4'b0001;
      bus.req_a[31:0] = ONE;
      bus.req_b[31:0] = TWO;
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL single_grant: got %b expected 0001", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = '0;
      n_checks++;
      if (bus.mul_act !== 1'b1 || bus.mul_in1 !== ONE || bus.mul_in2 !== TWO || bus.resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_issue: got act=%b in1=%h in2=%h rv=%b expected 1 %h %h 0", bus.mul_act, bus.mul_in1, bus.mul_in2, bus.resp_valid, ONE, TWO);
      end
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         n_checks++;
         if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b1 || bus.mul_act !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: cycle %0d got rv=%b busy=%b act=%b expected 0 1 0", c, bus.resp_valid, bus.busy, bus.mul_act);
         end
      end
      @(negedge clk);
      n_checks++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_flags} !== {1'b1, 2'd0, TWO, 4'h0}) begin
         n_fail++;
         $display("FAIL single_resp: got rv=%b id=%0d data=%h flags=%b expected 1 0 %h 0000", bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_flags, TWO);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      n_checks++;
      if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_drain: got rv=%b busy=%b expected 0 0", bus.resp_valid, bus.busy);
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] gq[$];
      int gc[$];
      logic [1:0] rq[$];
      logic [31:0] dq[$];
      logic [31:0] prod [4];
      prod[0] = 32'h4000_0000;
      prod[1] = 32'h4080_0000;
      prod[2] = 32'h40C0_0000;
      prod[3] = 32'h4100_0000;
      do_reset;
      bus.req_a = {32'h4080_0000, 32'h4040_0000, TWO, ONE};
      bus.req_b = {4{TWO}};
      bus.resp_ready = 1'b1;
      bus.req_valid = 4'hF;
      for (int c = 0; c < 30; c++) begin
         if (c == 20) bus.req_valid = '0;
         #1;
         for (int i = 0; i < 4; i++)
            if (bus.req_ready[i]) begin
               gq.push_back(2'(i));
               gc.push_back(c);
            end
         if (bus.resp_valid) begin
            rq.push_back(bus.resp_id);
            dq.push_back(bus.resp_data);
         end
         @(negedge clk);
      end
      n_checks++;
      if (gq.size() < 8) begin
         n_fail++;
         $display("FAIL rr_count: got %0d grants expected at least 8", gq.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (gq[i] !== 2'(i % 4)) begin
               n_fail++;
               $display("FAIL rr_order: grant %0d got %0d expected %0d", i, gq[i], i % 4);
            end
         end
         n_checks++;
         if (gc[0] != 0 || gc[3] != 3) begin
            n_fail++;
            $display("FAIL rr_rate: first grants at cycles %0d..%0d expected 0..3", gc[0], gc[3]);
         end
      end
      n_checks++;
      if (rq.size() != gq.size()) begin
         n_fail++;
         $display("FAIL rr_resp_count: got %0d responses expected %0d", rq.size(), gq.size());
      end
      for (int i = 0; i < rq.size(); i++) begin
         n_checks++;
         if (rq[i] !== 2'(i % 4) || dq[i] !== prod[i % 4]) begin
            n_fail++;
            $display("FAIL rr_resp: resp %0d got id=%0d data=%h expected id=%0d data=%h", i, rq[i], dq[i], i % 4, prod[i % 4]);
         end
      end
   endtask

   task automatic test_credit;
      int acc = 0;
      do_reset;
      bus.req_a[63:32] = 32'h4100_0000;
      bus.req_b[63:32] = ONE;
      bus.req_valid = 4'b0010;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (bus.req_ready[1]) acc++;
         @(negedge clk);
      end
      #1;
      n_checks++;
      if (acc != 4 || bus.req_ready !== 4'b0000 || bus.resp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL credit_fill: got accepts=%0d ready=%b rv=%b expected 4 0000 1", acc, bus.req_ready, bus.resp_valid);
      end
      bus.resp_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL credit_pop_cycle: got %b expected 0000", bus.req_ready);
      end
      @(negedge clk);
      bus.resp_ready = 1'b0;
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL credit_freed: got %b expected 0010", bus.req_ready);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL credit_single: got %b expected 0000", bus.req_ready);
      end
      bus.req_valid = '0;
   endtask

   task automatic test_exceptions;
      int got = 0;
      do_reset;
      bus.resp_ready = 1'b1;
      bus.req_a[95:64] = 32'h7F80_0000;
      bus.req_b[95:64] = 32'h0;
      bus.req_rm[8:6] = 3'd1;
      bus.req_a[127:96] = 32'h7F7F_FFFF;
      bus.req_b[127:96] = TWO;
      bus.req_valid = 4'b0100;
      @(negedge clk);
      n_checks++;
      if (bus.mul_act !== 1'b1 || bus.mul_in1 !== 32'h7F80_0000 || bus.mul_round_m !== 3'd1) begin
         n_fail++;
         $display("FAIL exc_issue: got act=%b in1=%h rm=%0d expected 1 7f800000 1", bus.mul_act, bus.mul_in1, bus.mul_round_m);
      end
      bus.req_valid = 4'b1000;
      @(negedge clk);
      bus.req_valid = '0;
      for (int c = 0; c < 10 && got < 2; c++) begin
         if (bus.resp_valid) begin
            n_checks++;
            if (got == 0 && {bus.resp_id, bus.resp_data, bus.resp_flags} !== {2'd2, 32'h7FC0_0000, 4'b1000}) begin
               n_fail++;
               $display("FAIL exc_inv: got id=%0d data=%h flags=%b expected 2 7fc00000 1000", bus.resp_id, bus.resp_data, bus.resp_flags);
            end
            if (got == 1 && {bus.resp_id, bus.resp_data, bus.resp_flags} !== {2'd3, 32'h7F80_0000, 4'b0101}) begin
               n_fail++;
               $display("FAIL exc_ov: got id=%0d data=%h flags=%b expected 3 7f800000 0101", bus.resp_id, bus.resp_data, bus.resp_flags);
            end
            got++;
         end
         @(negedge clk);
      end
      n_checks++;
      if (got != 2) begin
         n_fail++;
         $display("FAIL exc_timeout: got %0d responses expected 2", got);
      end
   endtask

   task automatic test_wrap;
      int got = 0;
      do_reset;
      bus.req_b[31:0] = ONE;
      for (int i = 0; i < 3; i++) begin
         bus.req_valid = 4'b0001;
         bus.req_a[31:0] = 32'h4100_0000 + i;
         @(negedge clk);
      end
      bus.req_valid = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (dut.count !== 3'd3 || bus.resp_data !== 32'h4100_0000) begin
         n_fail++;
         $display("FAIL wrap_fill: got count=%0d head=%h expected 3 41000000", dut.count, bus.resp_data);
      end
      bus.req_valid = 4'b0001;
      bus.req_a[31:0] = 32'h4100_0003;
      @(negedge clk);
      bus.req_valid = '0;
      repeat (2) @(negedge clk);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      n_checks++;
      if (dut.count !== 3'd3 || bus.resp_data !== 32'h4100_0001) begin
         n_fail++;
         $display("FAIL wrap_push_pop: got count=%0d head=%h expected 3 41000001", dut.count, bus.resp_data);
      end
      bus.resp_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         n_checks++;
         if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h4100_0000 + i) begin
            n_fail++;
            $display("FAIL wrap_order: entry %0d got rv=%b data=%h expected 1 %h", i, bus.resp_valid, bus.resp_data, 32'h4100_0000 + i);
         end
         @(negedge clk);
      end
      n_checks++;
      if (bus.resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_empty: got rv=%b expected 0", bus.resp_valid);
      end
      bus.req_valid = 4'b0001;
      bus.req_a[31:0] = 32'h4100_0004;
      @(negedge clk);
      bus.req_valid = '0;
      for (int c = 0; c < 8 && got == 0; c++) begin
         if (bus.resp_valid) begin
            got = 1;
            n_checks++;
            if (bus.resp_data !== 32'h4100_0004) begin
               n_fail++;
               $display("FAIL wrap_after: got %h expected 41000004", bus.resp_data);
            end
         end
         @(negedge clk);
      end
      n_checks++;
      if (got != 1) begin
         n_fail++;
         $display("FAIL wrap_timeout: got no response expected one");
      end
      bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset_midop;
      do_reset;
      bus.req_b[31:0] = ONE;
      bus.req_a[31:0] = 32'h4200_0000;
      bus.req_valid = 4'b0001;
      repeat (5) @(negedge clk);
      n_checks++;
      if (dut.count !== 3'd2 || bus.busy !== 1'b1 || bus.resp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL midop_setup: got count=%0d busy=%b rv=%b expected 2 1 1", dut.count, bus.busy, bus.resp_valid);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({bus.req_ready, bus.mul_act, bus.mul_in1, bus.mul_in2, bus.mul_round_m, bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_flags, bus.busy} !== 112'h0) begin
         n_fail++;
         $display("FAIL midop_reset: got ready=%b act=%b in1=%h rv=%b data=%h busy=%b expected all 0", bus.req_ready, bus.mul_act, bus.mul_in1, bus.resp_valid, bus.resp_data, bus.busy);
      end
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = '0;
      bus.resp_ready = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++;
      if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_stale: got rv=%b busy=%b expected 0 0", bus.resp_valid, bus.busy);
      end
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_rm = '0;
      bus.resp_ready = 1'b0;
      test_reset;
      test_single;
      test_back_to_back;
      test_credit;
      test_exceptions;
      test_wrap;
      test_reset_midop;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
